multi_cycle_ctrl: RTL
=====================

MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

Interface
REQ-001 The block SHALL have the port CLK, input, 1 bit: the single clock, rising-edge active.
REQ-002 The block SHALL have the port Reset, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have the port opcode, input, 6 bits: the IR[31:26] value, stable from ID onward.
REQ-004 The block SHALL have the port zero, input, 1 bit: the ALU zero flag, sampled in EXE_BR.
REQ-005 The block SHALL have these write-enable outputs, 1 bit each: PCWre, IRWre, RegWre, mRD, mWR.
REQ-006 The block SHALL have these select outputs, 1 bit each: ALUSrcA (1=sa), ALUSrcB (1=ext imm), WrRegDSrc (0=PC+4, 1=ALU/mem), DBDataSrc (1=mem).
REQ-007 The block SHALL have the output ExtSel, 1 bit: 1=sign extend, 0=zero extend.
REQ-008 The block SHALL have the output ALUOp, 3 bits: 000 add, 001 sub, 011 or, 100 and, 110 slt.
REQ-009 The block SHALL have the output RegDst, 2 bits, which drives the downstream 5-bit 4:1 write-address mux: 00 = $31, 01 = rt, 10 = rd, 11 unused.
REQ-010 The block SHALL have the output PCSrc, 2 bits: 00 PC+4, 01 branch, 10 jr, 11 jump.
REQ-011 The block SHALL have the output state, 3 bits: the current FSM state, for debug.

Function
REQ-012 Opcode decoding SHALL be: add 000000, sub 000001, addi 000010, ori 010000, and 010001, slt 100110, sw 110000, lw 110001, beq 110100, bne 110101, j 111000, jr 111001, jal 111010, halt 111111.
REQ-013 State encodings SHALL be: IF=000, ID=001, EXE_AL=110, WB_AL=111, EXE_BR=101, EXE_LS=010, MEM=011, WB_LD=100.
REQ-014 HALT SHALL be a flag register, not a state encoding.
REQ-015 State transitions SHALL occur on the CLK rising edge only.
REQ-016 All outputs SHALL be combinational functions of the registered state and opcode.
REQ-017 Transitions SHALL be: IF->ID on every cycle. From ID: R-type/addi/ori -> EXE_AL; beq/bne -> EXE_BR; lw/sw -> EXE_LS; j/jal/jr -> IF; halt -> IF with HALT flag set.
REQ-018 Transitions SHALL continue: EXE_AL->WB_AL->IF; EXE_BR->IF; EXE_LS->MEM; MEM->IF for sw; MEM->WB_LD for lw; WB_LD->IF.
REQ-019 An undefined opcode in ID SHALL return to IF with PCWre=1 (nop).
REQ-020 IRWre SHALL be 1 only in IF.
REQ-021 PCWre SHALL be 1 only in the final state of each instruction: ID for j/jal/jr/undefined, WB_AL, EXE_BR, MEM for sw, and WB_LD.
REQ-022 Instruction latencies SHALL therefore be: j/jr/jal 2 cycles, beq/bne 3 cycles, sw 4 cycles, R-type/imm 4 cycles, lw 5 cycles.
REQ-023 RegWre SHALL be 1 in WB_AL and WB_LD (RegDst=10 for R-type, 01 for addi/ori/lw), and in ID for jal (RegDst=00, WrRegDSrc=0).
REQ-024 mRD SHALL be 1 in MEM for lw; mWR SHALL be 1 in MEM for sw; they SHALL never both be 1.
REQ-025 In EXE_BR, ALUOp SHALL be 001 and PCSrc SHALL be 01 when (beq and zero=1) or (bne and zero=0); otherwise PCSrc SHALL be 00.
REQ-026 ExtSel SHALL be 0 for ori and 1 for all other instructions.
REQ-027 While HALT is set, the FSM SHALL hold IF with all write enables at 0, until Reset.
REQ-028 Outputs not explicitly asserted SHALL be 0.

Reset
REQ-029 When Reset=0, the block SHALL immediately (asynchronously) set state=IF and clear HALT.
REQ-030 While Reset=0, the block SHALL force every output to 0.
REQ-031 A reset mid-instruction SHALL abandon that instruction with no pending write.
REQ-032 After Reset rises, the first CLK edge SHALL occur in IF with IRWre=1.

Configuration
REQ-033 With CTRL_JUMP_EN defined, j, jal and jr SHALL decode as specified above.
REQ-034 Without CTRL_JUMP_EN, j, jal and jr SHALL decode as undefined (nop, 2 cycles, PCSrc=00, RegWre=0), and PCSrc values 10 and 11 SHALL never be driven.

Verification
REQ-035 Scenario: hold Reset=0 mid-EXE_AL, then release -> all outputs are 0 during reset, state=000 on release, IRWre=1.
REQ-036 Scenario: opcode=000000 -> states 000,001,110,111,000; RegWre=1 with RegDst=10 only in state 111; PCWre=1 only in state 111.
REQ-037 Scenario: opcode=110001 -> states 000,001,010,011,100; mRD=1 in 011; RegWre=1 with RegDst=01 and DBDataSrc=1 in 100.
REQ-038 Scenario: opcode=110100 with zero=1, then zero=0 -> PCSrc=01, then PCSrc=00, in state 101 with PCWre=1.
REQ-039 Scenario: opcode=111010 with CTRL_JUMP_EN -> in ID: RegWre=1, RegDst=00, PCSrc=11, PCWre=1; without the macro: RegWre=0, PCSrc=00.
REQ-040 Scenario: opcode=111111 -> after ID, state stays 000 with PCWre=IRWre=RegWre=0 for at least 10 cycles, until Reset.

Source files
------------

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle RISC control FSM: state register, next-state and output decode.
// Optional CTRL_JUMP_EN enables j/jal/jr; otherwise they decode as nops.
module multi_cycle_ctrl (
  input  logic       CLK,
  input  logic       Reset,
  input  logic [5:0] opcode,
  input  logic       zero,
  output logic       PCWre,
  output logic       IRWre,
  output logic       RegWre,
  output logic       mRD,
  output logic       mWR,
  output logic       ALUSrcA,
  output logic       ALUSrcB,
  output logic       WrRegDSrc,
  output logic       DBDataSrc,
  output logic       ExtSel,
  output logic [2:0] ALUOp,
  output logic [1:0] RegDst,
  output logic [1:0] PCSrc,
  output logic [2:0] state
);

  localparam logic [2:0] IF     = 3'b000;
  localparam logic [2:0] ID     = 3'b001;
  localparam logic [2:0] EXE_AL = 3'b110;
  localparam logic [2:0] WB_AL  = 3'b111;
  localparam logic [2:0] EXE_BR = 3'b101;
  localparam logic [2:0] EXE_LS = 3'b010;
  localparam logic [2:0] MEM    = 3'b011;
  localparam logic [2:0] WB_LD  = 3'b100;

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_SUB  = 6'b000001;
  localparam logic [5:0] OP_ADDI = 6'b000010;
  localparam logic [5:0] OP_ORI  = 6'b010000;
  localparam logic [5:0] OP_AND  = 6'b010001;
  localparam logic [5:0] OP_SLT  = 6'b100110;
  localparam logic [5:0] OP_SW   = 6'b110000;
  localparam logic [5:0] OP_LW   = 6'b110001;
  localparam logic [5:0] OP_BEQ  = 6'b110100;
  localparam logic [5:0] OP_BNE  = 6'b110101;
  localparam logic [5:0] OP_J    = 6'b111000;
  localparam logic [5:0] OP_JR   = 6'b111001;
  localparam logic [5:0] OP_JAL  = 6'b111010;
  localparam logic [5:0] OP_HALT = 6'b111111;

  logic [2:0] stateQ, stateD;
  logic       haltQ;

  logic isAdd, isSub, isAddi, isOri, isAnd, isSlt;
  logic isSw, isLw, isBeq, isBne, isHalt;
  logic isJ, isJr, isJal;
  logic isR, isImm, isAl, isBr, isLs;
  logic brTaken;
  logic [2:0] aluFn;

  assign isAdd  = opcode == OP_ADD;
  assign isSub  = opcode == OP_SUB;
  assign isAddi = opcode == OP_ADDI;
  assign isOri  = opcode == OP_ORI;
  assign isAnd  = opcode == OP_AND;
  assign isSlt  = opcode == OP_SLT;
  assign isSw   = opcode == OP_SW;
  assign isLw   = opcode == OP_LW;
  assign isBeq  = opcode == OP_BEQ;
  assign isBne  = opcode == OP_BNE;
  assign isHalt = opcode == OP_HALT;

`ifdef CTRL_JUMP_EN
  assign isJ   = opcode == OP_J;
  assign isJr  = opcode == OP_JR;
  assign isJal = opcode == OP_JAL;
`else
  assign isJ   = 1'b0;
  assign isJr  = 1'b0;
  assign isJal = 1'b0;
`endif

  assign isR   = isAdd | isSub | isAnd | isSlt;
  assign isImm = isAddi | isOri;
  assign isAl  = isR | isImm;
  assign isBr  = isBeq | isBne;
  assign isLs  = isLw | isSw;

  assign brTaken = (isBeq & zero) | (isBne & ~zero);

  always_comb begin
    aluFn = 3'b000;
    unique case (1'b1)
      isSub:  aluFn = 3'b001;
      isOri:  aluFn = 3'b011;
      isAnd:  aluFn = 3'b100;
      isSlt:  aluFn = 3'b110;
      default: aluFn = 3'b000;
    endcase
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      stateQ <= IF;
      haltQ  <= 1'b0;
    end else begin
      stateQ <= stateD;
      if (stateQ == ID && isHalt)
        haltQ <= 1'b1;
    end
  end

  always_comb begin
    stateD = IF;
    unique case (stateQ)
      IF:     stateD = haltQ ? IF : ID;
      ID: begin
        unique case (1'b1)
          isAl:    stateD = EXE_AL;
          isBr:    stateD = EXE_BR;
          isLs:    stateD = EXE_LS;
          default: stateD = IF;
        endcase
      end
      EXE_AL: stateD = WB_AL;
      WB_AL:  stateD = IF;
      EXE_BR: stateD = IF;
      EXE_LS: stateD = MEM;
      MEM:    stateD = isLw ? WB_LD : IF;
      WB_LD:  stateD = IF;
      default: stateD = IF;
    endcase
  end

  always_comb begin
    PCWre     = 1'b0;
    IRWre     = 1'b0;
    RegWre    = 1'b0;
    mRD       = 1'b0;
    mWR       = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 1'b0;
    WrRegDSrc = 1'b0;
    DBDataSrc = 1'b0;
    ExtSel    = 1'b0;
    ALUOp     = 3'b000;
    RegDst    = 2'b00;
    PCSrc     = 2'b00;
    // Reset and halt both force a quiet bus with no pending writes
    if (Reset && !haltQ) begin
      ExtSel = (stateQ != IF) && !isOri;
      unique case (stateQ)
        IF: IRWre = 1'b1;
        ID: begin
          if (!(isAl | isBr | isLs | isHalt))
            PCWre = 1'b1;
          if (isJal) begin
            RegWre = 1'b1;
            RegDst = 2'b00;
          end
          if (isJ | isJal)
            PCSrc = 2'b11;
          else if (isJr)
            PCSrc = 2'b10;
        end
        EXE_AL: begin
          ALUOp   = aluFn;
          ALUSrcB = isImm;
        end
        WB_AL: begin
          ALUOp     = aluFn;
          ALUSrcB   = isImm;
          PCWre     = 1'b1;
          RegWre    = 1'b1;
          WrRegDSrc = 1'b1;
          RegDst    = isR ? 2'b10 : 2'b01;
        end
        EXE_BR: begin
          ALUOp = 3'b001;
          PCWre = 1'b1;
          PCSrc = brTaken ? 2'b01 : 2'b00;
        end
        EXE_LS: begin
          ALUSrcB = 1'b1;
        end
        MEM: begin
          ALUSrcB = 1'b1;
          mRD     = isLw;
          mWR     = isSw;
          PCWre   = isSw;
        end
        WB_LD: begin
          ALUSrcB   = 1'b1;
          PCWre     = 1'b1;
          RegWre    = 1'b1;
          WrRegDSrc = 1'b1;
          DBDataSrc = 1'b1;
          RegDst    = 2'b01;
        end
        default: ;
      endcase
    end
  end

  assign state = Reset ? stateQ : 3'b000;

endmodule
